// File: rtl/tetris_ctrl_gen.sv
// Playfield controller: accepts 4x4 pieces, applies gravity and lateral moves with
// mask-vs-grid collision, locks pieces and collapses full rows one row test per cycle.
//
// state | meaning
// SPAWN | waiting for the generator to offer a piece
// FALL  | piece active; gravity, soft drop and lateral moves applied
// LOCK  | merge piece cells into the grid (one cycle)
// CLEAR | test rows bottom-up, collapse full ones
// OVER  | spawned piece collided; frozen until restart

module tetris_ctrl_gen #(
  parameter int ROWS   = 22,
  parameter int COLS   = 10,
  parameter int LINE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    move_left,
  input  logic                    move_right,
  input  logic                    soft_drop,
  input  logic                    restart,
  input  logic                    piece_valid,
  output logic                    piece_ready,
  input  logic [15:0]             piece_shape,
  input  logic [$clog2(COLS)-1:0] piece_col,
  output logic [ROWS*COLS-1:0]    display_array,
  output logic                    piece_locked,
  output logic [LINE_W-1:0]       lines_cleared,
  output logic                    game_over,
  output logic [2:0]              state_o
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS + 4);
  localparam int CW = $clog2(COLS + 4);
  localparam int XW = COLS + (1 << CW) + 4;

  typedef enum logic [2:0] {
    SPAWN = 3'd0,
    FALL  = 3'd1,
    LOCK  = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t         state;
  logic [N-1:0]   grid;
  logic [15:0]    shape;
  logic [RW-1:0]  row_pos;
  logic [RW-1:0]  scan_row;
  logic [CW-1:0]  col_pos;

  // In-range piece cells as a flat grid mask; cells past the edges are dropped here
  // and reported separately by off_field.
  function automatic logic [N-1:0] cell_mask(input logic [15:0] shp,
                                             input logic [RW-1:0] r0,
                                             input logic [CW-1:0] c0);
    logic [N-1:0]  m;
    logic [RW+1:0] rr;
    m = '0;
    for (int pr = 0; pr < 4; pr++) begin
      rr = (RW+2)'(r0) + (RW+2)'(pr);
      if (32'(rr) < ROWS)
        m = m | (N'(COLS'(shp[pr*4 +: 4]) << c0) << (32'(rr) * COLS));
    end
    return m;
  endfunction

  function automatic logic off_field(input logic [15:0] shp,
                                     input logic [RW-1:0] r0,
                                     input logic [CW-1:0] c0);
    logic          bad;
    logic [RW+1:0] rr;
    bad = 1'b0;
    for (int pr = 0; pr < 4; pr++) begin
      rr = (RW+2)'(r0) + (RW+2)'(pr);
      if (|((XW'(shp[pr*4 +: 4]) << c0) >> COLS))
        bad = 1'b1;
      if ((|shp[pr*4 +: 4]) && (32'(rr) >= ROWS))
        bad = 1'b1;
    end
    return bad;
  endfunction

  logic [N-1:0]  cur_mask;
  logic [RW-1:0] row_dn;
  logic [CW-1:0] col_lf;
  logic [CW-1:0] col_rt;
  logic [CW-1:0] col_sp;
  logic          dn_hit;
  logic          lf_hit;
  logic          rt_hit;
  logic          sp_hit;

  assign row_dn   = row_pos + RW'(1);
  assign col_lf   = col_pos - CW'(1);
  assign col_rt   = col_pos + CW'(1);
  assign col_sp   = CW'(piece_col);
  assign cur_mask = cell_mask(shape, row_pos, col_pos);

  assign dn_hit = off_field(shape, row_dn, col_pos)
                | (|(cell_mask(shape, row_dn, col_pos) & grid));
  assign lf_hit = off_field(shape, row_pos, col_lf)
                | (|(cell_mask(shape, row_pos, col_lf) & grid));
  assign rt_hit = off_field(shape, row_pos, col_rt)
                | (|(cell_mask(shape, row_pos, col_rt) & grid));
  assign sp_hit = off_field(piece_shape, '0, col_sp)
                | (|(cell_mask(piece_shape, '0, col_sp) & grid));

  logic         row_full;
  logic [N-1:0] grid_shift;

  // Collapse: every row at or above scan_row takes the row above it, row 0 empties.
  always_comb begin
    row_full   = &(COLS'(grid >> (32'(scan_row) * COLS)));
    grid_shift = grid;
    grid_shift[COLS-1:0] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(scan_row))
        grid_shift[r*COLS +: COLS] = grid[(r-1)*COLS +: COLS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SPAWN;
      grid          <= '0;
      shape         <= '0;
      row_pos       <= '0;
      col_pos       <= '0;
      scan_row      <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      piece_locked  <= 1'b0;
    end else begin
      piece_locked <= 1'b0;
      if (restart) begin
        state         <= SPAWN;
        grid          <= '0;
        shape         <= '0;
        row_pos       <= '0;
        col_pos       <= '0;
        scan_row      <= '0;
        lines_cleared <= '0;
        game_over     <= 1'b0;
      end else begin
        case (state)
          SPAWN: begin
            if (piece_valid) begin
              shape   <= piece_shape;
              row_pos <= '0;
              col_pos <= col_sp;
              if (sp_hit) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= FALL;
              end
            end
          end
          FALL: begin
            if (tick || soft_drop) begin
              if (dn_hit) begin
                state        <= LOCK;
                piece_locked <= 1'b1;
              end else begin
                row_pos <= row_dn;
              end
            end else if (move_left && !move_right) begin
              if ((col_pos != '0) && !lf_hit)
                col_pos <= col_lf;
            end else if (move_right && !move_left) begin
              if (!rt_hit)
                col_pos <= col_rt;
            end
          end
          LOCK: begin
            grid     <= grid | cur_mask;
            scan_row <= RW'(ROWS - 1);
            state    <= CLEAR;
          end
          CLEAR: begin
            if (row_full) begin
              grid <= grid_shift;
              if (lines_cleared != '1)
                lines_cleared <= lines_cleared + LINE_W'(1);
            end else if (scan_row == '0) begin
              state <= SPAWN;
            end else begin
              scan_row <= scan_row - RW'(1);
            end
          end
          OVER: begin
          end
          default: state <= SPAWN;
        endcase
      end
    end
  end

  assign piece_ready   = (state == SPAWN);
  assign display_array = (state == FALL) ? (grid | cur_mask) : grid;
  assign state_o       = state;

endmodule

// File: tb/tb_tetris_ctrl_gen.sv
// Bench for tetris_ctrl_gen: a bench-side playfield model predicts landing rows,
// merged/compacted grids and clear durations; results are queued and compared on return to SPAWN.

module tb_tetris_ctrl_gen;
  localparam int ROWS   = 22;
  localparam int COLS   = 10;
  localparam int LINE_W = 16;
  localparam int N      = ROWS * COLS;
  localparam logic [2:0] S_SPAWN = 3'd0, S_FALL = 3'd1, S_LOCK = 3'd2,
                         S_CLEAR = 3'd3, S_OVER = 3'd4;

  logic              clk, rst_n, tick, move_left, move_right, soft_drop, restart;
  logic              piece_valid, piece_ready, piece_locked, game_over;
  logic [15:0]       piece_shape;
  logic [3:0]        piece_col;
  logic [N-1:0]      display_array;
  logic [LINE_W-1:0] lines_cleared;
  logic [2:0]        state_o;

  tetris_ctrl_gen #(.ROWS(ROWS), .COLS(COLS), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .move_left(move_left),
    .move_right(move_right), .soft_drop(soft_drop), .restart(restart),
    .piece_valid(piece_valid), .piece_ready(piece_ready), .piece_shape(piece_shape),
    .piece_col(piece_col), .display_array(display_array), .piece_locked(piece_locked),
    .lines_cleared(lines_cleared), .game_over(game_over), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grid;
    int           lines;
    int           nclr;
  } exp_t;
  exp_t sb[$];

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] mg;
  int           mlines;
  logic [15:0]  cshape;
  int           crow, ccol;

  function automatic bit fits(input logic [15:0] s, input int r0, input int c0,
                              input logic [N-1:0] g);
    for (int i = 0; i < 16; i++) begin
      if (s[i]) begin
        int r;
        int c;
        r = r0 + i / 4;
        c = c0 + i % 4;
        if (r >= ROWS || c >= COLS || c < 0) return 1'b0;
        if (g[r*COLS + c]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] place(input logic [15:0] s, input int r0, input int c0);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) begin
        int r;
        int c;
        r = r0 + i / 4;
        c = c0 + i % 4;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) p[r*COLS + c] = 1'b1;
      end
    end
    return p;
  endfunction

  // Keeps non-full rows in order, packed against the floor.
  function automatic logic [N-1:0] compact(input logic [N-1:0] g, output int n);
    logic [N-1:0] o;
    int dst;
    o = '0;
    dst = ROWS - 1;
    n = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (&g[r*COLS +: COLS]) n++;
      else begin
        o[dst*COLS +: COLS] = g[r*COLS +: COLS];
        dst--;
      end
    end
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input logic [15:0] s, input int col);
    int n;
    n = 0;
    while (piece_ready !== 1'b1 && n < 200) begin cyc(); n++; end
    checks++;
    if (piece_ready !== 1'b1) begin
      errors++; $display("FAIL spawn_ready: got %b want 1", piece_ready);
    end
    piece_valid = 1'b1; piece_shape = s; piece_col = 4'(col);
    cyc();
    piece_valid = 1'b0;
    if (fits(s, 0, col, mg)) begin
      cshape = s; crow = 0; ccol = col;
      checks++;
      if (state_o !== S_FALL || display_array !== (mg | place(s, 0, col))) begin
        errors++; $display("FAIL spawn_fall: state %0d display %h want state 1 display %h",
                           state_o, display_array, mg | place(s, 0, col));
      end
    end else begin
      checks++;
      if (state_o !== S_OVER || game_over !== 1'b1 || piece_ready !== 1'b0 ||
          display_array !== mg) begin
        errors++; $display("FAIL spawn_over: state %0d go %b rdy %b want state 4 go 1 rdy 0",
                           state_o, game_over, piece_ready);
      end
    end
  endtask

  task automatic move(input logic l, input logic r, input logic t, input logic sd,
                      input string name);
    move_left = l; move_right = r; tick = t; soft_drop = sd;
    cyc();
    move_left = 0; move_right = 0; tick = 0; soft_drop = 0;
    if (t || sd) begin
      if (fits(cshape, crow + 1, ccol, mg)) crow++;
    end else if (l && !r) begin
      if (ccol > 0 && fits(cshape, crow, ccol - 1, mg)) ccol--;
    end else if (r && !l) begin
      if (fits(cshape, crow, ccol + 1, mg)) ccol++;
    end
    checks++;
    if (state_o !== S_FALL || display_array !== (mg | place(cshape, crow, ccol))) begin
      errors++; $display("FAIL %s: state %0d display %h want display %h", name, state_o,
                         display_array, mg | place(cshape, crow, ccol));
    end
  endtask

  task automatic drop();
    int rest, nt, n, cl, k;
    exp_t e;
    rest = crow;
    while (fits(cshape, rest + 1, ccol, mg)) rest++;
    nt = rest - crow + 1;
    e.grid  = compact(mg | place(cshape, rest, ccol), k);
    e.lines = mlines + k;
    e.nclr  = ROWS + k;
    sb.push_back(e);
    n = 0;
    while (state_o === S_FALL && n < 40) begin tick = 1'b1; cyc(); tick = 1'b0; n++; end
    checks++;
    if (n != nt) begin errors++; $display("FAIL drop_ticks: got %0d want %0d", n, nt); end
    checks++;
    if (state_o !== S_LOCK || piece_locked !== 1'b1) begin
      errors++; $display("FAIL lock_pulse: state %0d locked %b want 2 1", state_o, piece_locked);
    end
    cyc();
    checks++;
    if (state_o !== S_CLEAR || piece_locked !== 1'b0) begin
      errors++; $display("FAIL lock_end: state %0d locked %b want 3 0", state_o, piece_locked);
    end
    cl = 0;
    while (state_o === S_CLEAR && cl < 100) begin cyc(); cl++; end
    e = sb.pop_front();
    checks++;
    if (state_o !== S_SPAWN) begin
      errors++; $display("FAIL clear_exit: state %0d want 0", state_o);
    end
    checks++;
    if (cl != e.nclr) begin errors++; $display("FAIL clear_cycles: got %0d want %0d", cl, e.nclr); end
    checks++;
    if (display_array !== e.grid) begin
      errors++; $display("FAIL grid_after_lock: got %h want %h", display_array, e.grid);
    end
    checks++;
    if (lines_cleared !== 16'(e.lines)) begin
      errors++; $display("FAIL lines: got %0d want %0d", lines_cleared, e.lines);
    end
    mg = e.grid; mlines = e.lines;
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if (state_o !== S_SPAWN || display_array !== '0 || lines_cleared !== '0 ||
        game_over !== 1'b0 || piece_locked !== 1'b0 || piece_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: state %0d lines %0d go %b lk %b rdy %b", state_o,
                         lines_cleared, game_over, piece_locked, piece_ready);
    end
    rst_n = 1'b1;
    cyc();
    mg = '0; mlines = 0;
  endtask

  task automatic test_gravity();
    logic [N-1:0] e;
    spawn(16'h0033, 4);
    for (int i = 0; i < 20; i++) move(0, 0, 1, 0, "gravity_step");
    drop();
    e = '0;
    e[20*COLS+4] = 1'b1; e[20*COLS+5] = 1'b1; e[21*COLS+4] = 1'b1; e[21*COLS+5] = 1'b1;
    checks++;
    if (display_array !== e) begin
      errors++; $display("FAIL o_piece_floor: got %h want %h", display_array, e);
    end
  endtask

  task automatic test_lateral();
    logic [N-1:0] e;
    spawn(16'h000F, 0);
    move(1, 0, 0, 0, "left_wall");
    for (int i = 0; i < 8; i++) move(0, 1, 0, 0, "right_step");
    e = mg;
    for (int c = 6; c < 10; c++) e[c] = 1'b1;
    checks++;
    if (display_array !== e) begin
      errors++; $display("FAIL right_wall: got %h want %h", display_array, e);
    end
    drop();
  endtask

  task automatic test_restart();
    restart = 1'b1; cyc(); restart = 1'b0;
    checks++;
    if (display_array !== '0 || lines_cleared !== '0 || state_o !== S_SPAWN || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: state %0d lines %0d go %b", state_o, lines_cleared, game_over);
    end
    mg = '0; mlines = 0;
  endtask

  task automatic test_line_clear();
    logic [N-1:0] e;
    spawn(16'h000F, 0); drop();
    spawn(16'h000F, 4); drop();
    spawn(16'h1111, 8); drop();
    spawn(16'h1111, 9); drop();
    e = '0;
    for (int r = 19; r < 22; r++) begin e[r*COLS+8] = 1'b1; e[r*COLS+9] = 1'b1; end
    checks++;
    if (display_array !== e || lines_cleared !== 16'd1) begin
      errors++; $display("FAIL single_clear: lines %0d grid %h want 1 grid %h",
                         lines_cleared, display_array, e);
    end
  endtask

  task automatic test_double_clear();
    for (int c = 0; c < 8; c += 2) begin spawn(16'h0033, c); drop(); end
    checks++;
    if (lines_cleared !== 16'd3) begin
      errors++; $display("FAIL double_clear: lines %0d want 3", lines_cleared);
    end
  endtask

  task automatic test_priority_and_reset();
    logic [N-1:0] e;
    int n;
    spawn(16'h0033, 0);
    move(0, 1, 1, 0, "tick_beats_right");
    e = mg;
    e[1*COLS+0] = 1'b1; e[1*COLS+1] = 1'b1; e[2*COLS+0] = 1'b1; e[2*COLS+1] = 1'b1;
    checks++;
    if (display_array !== e) begin
      errors++; $display("FAIL tick_priority: got %h want %h", display_array, e);
    end
    move(1, 1, 0, 0, "left_and_right");
    move(1, 0, 0, 1, "drop_beats_left");
    n = 0;
    while (state_o === S_FALL && n < 40) begin tick = 1'b1; cyc(); tick = 1'b0; n++; end
    cyc(); cyc();
    checks++;
    if (state_o !== S_CLEAR) begin errors++; $display("FAIL reach_clear: state %0d want 3", state_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== S_SPAWN || display_array !== '0 || lines_cleared !== '0 ||
        game_over !== 1'b0 || piece_locked !== 1'b0) begin
      errors++; $display("FAIL reset_in_clear: state %0d lines %0d disp_nonzero %b", state_o,
                         lines_cleared, |display_array);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    mg = '0; mlines = 0;
  endtask

  task automatic test_game_over();
    for (int k = 0; k < 11; k++) begin spawn(16'h0033, 4); drop(); end
    checks++;
    if (display_array[4] !== 1'b1 || display_array[COLS+4] !== 1'b1) begin
      errors++; $display("FAIL top_filled: r0c4 %b r1c4 %b want 1 1",
                         display_array[4], display_array[COLS+4]);
    end
    spawn(16'h0033, 4);
    tick = 1; move_left = 1; soft_drop = 1; piece_valid = 1;
    cyc();
    tick = 0; move_left = 0; soft_drop = 0; piece_valid = 0;
    checks++;
    if (state_o !== S_OVER || display_array !== mg || game_over !== 1'b1) begin
      errors++; $display("FAIL over_hold: state %0d go %b want 4 1", state_o, game_over);
    end
    restart = 1'b1; cyc(); restart = 1'b0;
    checks++;
    if (state_o !== S_SPAWN || display_array !== '0 || game_over !== 1'b0 || piece_ready !== 1'b1) begin
      errors++; $display("FAIL over_restart: state %0d go %b rdy %b want 0 0 1", state_o,
                         game_over, piece_ready);
    end
    mg = '0; mlines = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tick = 0; move_left = 0; move_right = 0; soft_drop = 0; restart = 0;
    piece_valid = 0; piece_shape = '0; piece_col = '0;
    test_reset();
    test_gravity();
    test_lateral();
    test_restart();
    test_line_clear();
    test_double_clear();
    test_priority_and_reset();
    test_game_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
